// File: rtl/image_streamer.sv
// image_streamer: frame buffer streamed out in raster order, one pixel per cycle, with window_valid flags.
// Optional STREAMER_HOLD_EN adds a hold input that stalls the stream without losing pixels.
module image_streamer #(
  parameter int BITS        = 9,
  parameter int KERNEL_SIZE = 3,
  parameter int IMG_LENGTH  = 16,
  parameter int IMG_HEIGHT  = 16,
  localparam int ADDR_W     = $clog2(IMG_LENGTH*IMG_HEIGHT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [BITS-1:0]   ld_data,
  input  logic              start,
`ifdef STREAMER_HOLD_EN
  input  logic              hold,
`endif
  output logic              busy,
  output logic              write_en,
  output logic [BITS-1:0]   serial_img_out,
  output logic              window_valid,
  output logic              frame_done
);
  localparam int NPIX  = IMG_LENGTH*IMG_HEIGHT;
  localparam int COL_W = (IMG_LENGTH > 1) ? $clog2(IMG_LENGTH) : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NPIX-1);
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(IMG_LENGTH-1);
  localparam logic [COL_W-1:0]  WIN_COL  = COL_W'(KERNEL_SIZE-1);
  localparam logic [ROW_W-1:0]  WIN_ROW  = ROW_W'(KERNEL_SIZE-1);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              busy_q, busy_d;
  logic              write_en_q, write_en_d;
  logic [BITS-1:0]   serial_img_out_q, serial_img_out_d;
  logic              window_valid_q, window_valid_d;
  logic              frame_done_q, frame_done_d;
  logic              stall;

  logic [BITS-1:0]   mem [NPIX];

`ifdef STREAMER_HOLD_EN
  assign stall = hold;
`else
  assign stall = 1'b0;
`endif

  // Frame buffer is deliberately not reset; writes are dropped while a frame is being read.
  always_ff @(posedge clk) begin
    if (ld_en && state_q != STREAM) begin
      mem[ld_addr] <= ld_data;
    end
  end

  // STREAM state runs one cycle ahead of the registered outputs (the memory read stage),
  // so the state is already DONE while the last pixel is on the outputs.
  always_comb begin
    state_d          = state_q;
    idx_d            = idx_q;
    col_d            = col_q;
    row_d            = row_q;
    busy_d           = 1'b0;
    write_en_d       = 1'b0;
    serial_img_out_d = serial_img_out_q;
    window_valid_d   = 1'b0;
    frame_done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = STREAM;
          idx_d   = '0;
          col_d   = '0;
          row_d   = '0;
        end
      end
      STREAM: begin
        busy_d = 1'b1;
        if (!stall) begin
          write_en_d       = 1'b1;
          serial_img_out_d = mem[idx_q];
          window_valid_d   = (row_q >= WIN_ROW) && (col_q >= WIN_COL);
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
          if (col_q == COL_LAST) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      DONE: begin
        frame_done_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      idx_q            <= '0;
      col_q            <= '0;
      row_q            <= '0;
      busy_q           <= 1'b0;
      write_en_q       <= 1'b0;
      serial_img_out_q <= '0;
      window_valid_q   <= 1'b0;
      frame_done_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      idx_q            <= idx_d;
      col_q            <= col_d;
      row_q            <= row_d;
      busy_q           <= busy_d;
      write_en_q       <= write_en_d;
      serial_img_out_q <= serial_img_out_d;
      window_valid_q   <= window_valid_d;
      frame_done_q     <= frame_done_d;
    end
  end

  assign busy           = busy_q;
  assign write_en       = write_en_q;
  assign serial_img_out = serial_img_out_q;
  assign window_valid   = window_valid_q;
  assign frame_done     = frame_done_q;
endmodule

// File: tb/tb_image_streamer.sv
// Scoreboard bench for image_streamer: stimulus pushes expected pixels, a negedge monitor pops and compares.
module tb_image_streamer;
  localparam int BITS = 9;
  localparam int K    = 3;
  localparam int L    = 16;
  localparam int H    = 16;
  localparam int NPIX = L*H;
  localparam int AW   = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            ld_en = 1'b0;
  logic [AW-1:0]   ld_addr = '0;
  logic [BITS-1:0] ld_data = '0;
  logic            start = 1'b0;
`ifdef STREAMER_HOLD_EN
  logic            hold = 1'b0;
`endif
  logic            busy, write_en, window_valid, frame_done;
  logic [BITS-1:0] serial_img_out;

  always #5 clk = ~clk;

  image_streamer dut (
    .clk(clk),
    .reset(reset),
    .ld_en(ld_en),
    .ld_addr(ld_addr),
    .ld_data(ld_data),
    .start(start),
`ifdef STREAMER_HOLD_EN
    .hold(hold),
`endif
    .busy(busy),
    .write_en(write_en),
    .serial_img_out(serial_img_out),
    .window_valid(window_valid),
    .frame_done(frame_done)
  );

  typedef struct packed {
    logic [BITS-1:0] pix;
    logic            wv;
    logic            last;
  } exp_t;

  exp_t            exp_q[$];
  exp_t            mon_e;
  logic [BITS-1:0] img [NPIX];
  int total = 0;
  int bad = 0;
  logic fd_exp = 1'b0;
  logic in_frame = 1'b0;
  int gap = 0;
  int last_gap = -1;
  int gaps_seen = 0;
  int pix_idx = 0;
  int wv_count = 0;
  int first_wv = -1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected stream from the bench's own copy of the frame; 'full' marks the final pixel.
  task automatic push_frame(input int count, input bit full);
    exp_t e;
    for (int i = 0; i < count; i++) begin
      e.pix  = img[i];
      e.wv   = ((i / L) >= K-1) && ((i % L) >= K-1);
      e.last = full && (i == NPIX-1);
      exp_q.push_back(e);
    end
  endtask

  task automatic drain(input int budget, input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_drain"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (3) tick();
  endtask

  task automatic clear_stats();
    wv_count  = 0;
    first_wv  = -1;
    gaps_seen = 0;
  endtask

  always @(negedge clk) begin
    if (frame_done || fd_exp) check("frame_done", 32'(frame_done), 32'(fd_exp));
    fd_exp = 1'b0;
    if (write_en) begin
      if (!in_frame) begin
        last_gap = gap;
        pix_idx  = 0;
      end else begin
        pix_idx++;
      end
      gap = 0;
      if (window_valid) begin
        if (wv_count == 0) first_wv = pix_idx;
        wv_count++;
      end
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_pixel got=%0h want=none at %0t", serial_img_out, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("pixel", 32'(serial_img_out), 32'(mon_e.pix));
        check("window_valid", 32'(window_valid), 32'(mon_e.wv));
        check("busy_stream", 32'(busy), 32'd1);
        in_frame = 1'b1;
        if (mon_e.last) begin
          in_frame = 1'b0;
          fd_exp   = 1'b1;
        end
      end
    end else begin
      gap++;
      if (in_frame) gaps_seen++;
      check("wv_idle", 32'(window_valid), 32'd0);
    end
  end

  initial begin
    // reset state
    repeat (2) tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_write_en", 32'(write_en), 32'd0);
    check("rst_window_valid", 32'(window_valid), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_serial", 32'(serial_img_out), 32'd0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < NPIX; i++) begin
      ld_en   = 1'b1;
      ld_addr = AW'(i);
      ld_data = BITS'(i);
      img[i]  = BITS'(i);
      tick();
    end
    ld_en = 1'b0;
    tick();

    // full frame, with a stray start pulse mid-stream
    clear_stats();
    push_frame(NPIX, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (50) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    drain(700, "frame1");
    check("frame1_gaps", 32'(gaps_seen), 32'd0);
    check("frame1_wv_count", 32'(wv_count), 32'd196);
    check("frame1_first_wv", 32'(first_wv), 32'd34);
    check("idle_busy", 32'(busy), 32'd0);

    // write during stream is dropped
    clear_stats();
    push_frame(NPIX, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    ld_en   = 1'b1;
    ld_addr = 8'd5;
    ld_data = 9'h1FF;
    tick();
    ld_en = 1'b0;
    drain(700, "drop_write");
    clear_stats();
    push_frame(NPIX, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    drain(700, "after_drop");

    // load coinciding with start lands before the first read
    clear_stats();
    img[5] = 9'h1FF;
    push_frame(NPIX, 1'b1);
    ld_en   = 1'b1;
    ld_addr = 8'd5;
    ld_data = 9'h1FF;
    start   = 1'b1;
    tick();
    ld_en = 1'b0;
    start = 1'b0;
    drain(700, "load_start");

    // reset while pixel 100 is on the outputs
    push_frame(101, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (101) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_write_en", 32'(write_en), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_frame_done", 32'(frame_done), 32'd0);
    check("midrst_left", 32'(exp_q.size()), 32'd0);
    in_frame = 1'b0;
    repeat (3) tick();
    clear_stats();
    push_frame(NPIX, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    drain(700, "after_reset");

    // start held high: two frames back to back
    push_frame(NPIX, 1'b1);
    push_frame(NPIX, 1'b1);
    start = 1'b1;
    repeat (300) tick();
    start = 1'b0;
    drain(900, "back_to_back");
    check("b2b_gap", 32'(last_gap), 32'd2);

`ifdef STREAMER_HOLD_EN
    clear_stats();
    push_frame(NPIX, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (41) tick();
    hold = 1'b1;
    repeat (3) tick();
    hold = 1'b0;
    drain(700, "hold");
    check("hold_gaps", 32'(gaps_seen), 32'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
